// File: rtl/dff_share_arbiter_pkg.sv
// Shared types and helpers for the shared capture-register arbiter.
// Holds the sequencer state encoding and the index-width helpers used by
// the interface, the picker and the top level.
package dff_share_arbiter_pkg;

    // Sequencer states: arbitrating, burst in progress, one-cycle release marker.
    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_REL    = 2'd2
    } state_e;

    // Width of the burst counter; wide enough for MAXLOCK up to 15.
    localparam int BURST_W = 4;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index width for N requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared capture register.
// master = the requester cluster, slave = the arbiter.
interface dff_share_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    import dff_share_arbiter_pkg::*;

    localparam int OW = idx_w(N);

    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [W-1:0]   q;
    logic           qvalid;
    logic [OW-1:0]  owner;

    modport master (
        output req,
        output lock,
        output data,
        input  grant,
        input  q,
        input  qvalid,
        input  owner
    );

    modport slave (
        input  req,
        input  lock,
        input  data,
        output grant,
        output q,
        output qvalid,
        output owner
    );

endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates the request vector so that position 0 is the requester at ptr,
// then takes the lowest active rotated position. sel is reported as the
// original (unrotated) requester index.
module dff_share_arbiter_rr_pick
    import dff_share_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [idx_w(N)-1:0]  ptr,
    output logic                 found,
    output logic [idx_w(N)-1:0]  sel
);

    localparam int OW = idx_w(N);

    logic [N-1:0]  rot_req;
    logic [OW-1:0] rot_idx [N];

    // ptr is always < N and gi < N, so a single conditional subtract
    // is enough to wrap the sum back into 0..N-1.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [OW:0] sum;
            assign sum         = {1'b0, ptr} + (OW+1)'(gi);
            assign rot_idx[gi] = (sum >= (OW+1)'(N)) ? OW'(sum - (OW+1)'(N)) : OW'(sum);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Priority scan from the highest rotated slot down, so the nearest one to ptr wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                found = 1'b1;
                sel   = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter and load sequencer for one shared W-bit capture register.
// Each cycle one requester is chosen, its lane is captured into Q and Grant
// reports the winner. A winner holding Lock keeps the register for up to
// MAXLOCK consecutive loads; afterwards it drops to lowest priority.
module dff_share_arbiter
    import dff_share_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int MAXLOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dff_share_arbiter_if.slave   bus
);

    localparam int OW = idx_w(N);

    // Architectural state; every output is driven straight from a register.
    state_e               state_reg;
    logic [OW-1:0]        ptr_reg;
    logic [OW-1:0]        owner_reg;
    logic [BURST_W-1:0]   burst_cnt_reg;
    logic [W-1:0]         q_reg;
    logic [N-1:0]         grant_reg;
    logic                 qvalid_reg;

    // Picker results and derived per-cycle values.
    logic                 pick_found;
    logic [OW-1:0]        pick_sel;
    logic [OW-1:0]        ptr_next;
    logic [W-1:0]         lane [N];
    logic [W-1:0]         win_data;
    logic [W-1:0]         own_data;
    logic                 burst_continue;

    // Split the flattened data bus into per-requester lanes.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign lane[gi] = bus.data[gi*W +: W];
        end
    endgenerate

    dff_share_arbiter_rr_pick #(
        .N (N)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .sel   (pick_sel)
    );

    // Only the selected lane ever reaches Q; other lanes are don't-care.
    assign win_data = lane[pick_sel];
    assign own_data = lane[owner_reg];

    // After a win the pointer moves just past the winner, wrapping N-1 -> 0.
    assign ptr_next = (pick_sel == OW'(N - 1)) ? '0 : pick_sel + OW'(1);

    // A burst keeps going only while its owner still requests, still locks,
    // and has not yet used its MAXLOCK loads.
    assign burst_continue = bus.req[owner_reg] & bus.lock[owner_reg]
                          & (burst_cnt_reg < BURST_W'(MAXLOCK));

    // Sequencer: arbitration, burst continuation and release, with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_ARB;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            q_reg         <= '0;
            grant_reg     <= '0;
            qvalid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOCKED: begin
                    if (burst_continue) begin
                        grant_reg     <= N'(1) << owner_reg;
                        q_reg         <= own_data;
                        qvalid_reg    <= 1'b1;
                        burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
                    end else begin
                        // Exit edge: nothing loaded, Q holds its last burst value.
                        grant_reg     <= '0;
                        qvalid_reg    <= 1'b0;
                        burst_cnt_reg <= '0;
                        state_reg     <= ST_REL;
                    end
                end
                default: begin
                    // ST_ARB and ST_REL arbitrate identically; REL only marks the exit.
                    if (pick_found) begin
                        grant_reg  <= N'(1) << pick_sel;
                        q_reg      <= win_data;
                        qvalid_reg <= 1'b1;
                        owner_reg  <= pick_sel;
                        ptr_reg    <= ptr_next;
                        if (bus.lock[pick_sel]) begin
                            state_reg     <= ST_LOCKED;
                            burst_cnt_reg <= BURST_W'(1);
                        end else begin
                            state_reg     <= ST_ARB;
                            burst_cnt_reg <= '0;
                        end
                    end else begin
                        grant_reg  <= '0;
                        qvalid_reg <= 1'b0;
                        state_reg  <= ST_ARB;
                    end
                end
            endcase
        end
    end

    assign bus.grant  = grant_reg;
    assign bus.q      = q_reg;
    assign bus.qvalid = qvalid_reg;
    assign bus.owner  = owner_reg;

endmodule
